// File: rtl/mem_model_pkg.sv
// Shared constants and helpers for the memory-model buffering blocks.
package mem_model_pkg;

  localparam int MEM_MODEL_SHOWAHEAD = 1;
  localparam int MEM_MODEL_REGREAD   = 0;

  // Level/pointer width: one extra bit so a full FIFO is distinguishable from empty.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_model_dpram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port.
module mem_model_dpram #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 44,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_model_fifo.sv
// Single-clock FIFO with show-ahead/registered read, programmable thresholds,
// registered level and sticky overflow/underflow flags.
module mem_model_fifo
  import mem_model_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 44,
  parameter  int FWFT  = MEM_MODEL_SHOWAHEAD,
  localparam int LW    = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             write,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic [LW-1:0]    afull_thresh,
  input  logic [LW-1:0]    aempty_thresh,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [LW-1:0]    wptr;
  logic [LW-1:0]    rptr;
  logic [LW-1:0]    level_next;
  logic [WIDTH-1:0] mem_rdata;
  logic             rd_ok;
  logic             wr_ok;

  // A write at full still goes in when a read frees a slot in the same cycle.
  assign rd_ok      = read & ~empty;
  assign wr_ok      = write & (~full | rd_ok);
  assign level_next = level + LW'(wr_ok) - LW'(rd_ok);

  mem_model_dpram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_dpram (
    .clk   (clk),
    .we    (wr_ok & ~clr),
    .waddr (wptr[LW-2:0]),
    .wdata (wdata),
    .raddr (rptr[LW-2:0]),
    .rdata (mem_rdata)
  );

  // Flags are registered from level_next so they always agree with level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      level        <= level_next;
      empty        <= (level_next == '0);
      full         <= (level_next == LW'(DEPTH));
      almost_full  <= (level_next >= afull_thresh);
      almost_empty <= (level_next <= aempty_thresh);
      if (write & ~wr_ok) overflow  <= 1'b1;
      if (read & ~rd_ok)  underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != MEM_MODEL_REGREAD) begin : g_showahead
      assign rdata  = mem_rdata;
      assign rvalid = ~empty;
    end else begin : g_regread
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;

      // rdata holds across clr and idle cycles; only rvalid is cleared.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (clr) begin
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_ok;
          if (rd_ok) rdata_q <= mem_rdata;
        end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
    end
  endgenerate

endmodule
